// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, receiver/transmitter state encoding
// and the bit-timer counter width helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_state_e;

    function automatic int cnt_width(input int cpb);
        return (cpb < 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: counts 0..clk_per_bit-1 and wraps; restart holds/forces the count to 0.
// mid_tick fires at clk_per_bit/2, end_tick on the last count of the bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int clk_per_bit = 87
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic mid_tick,
    output logic end_tick
);

    localparam int CW = cnt_width(clk_per_bit);
    localparam logic [CW-1:0] MID_CNT = CW'(clk_per_bit / 2);
    localparam logic [CW-1:0] END_CNT = CW'(clk_per_bit - 1);

    logic [CW-1:0] clk_cnt_q;
    logic [CW-1:0] clk_cnt_d;

    assign mid_tick = (clk_cnt_q == MID_CNT);
    assign end_tick = (clk_cnt_q == END_CNT);

    always_comb begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (restart || end_tick) begin
            clk_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver; frame is presented 2 cycles after the last stop sample
// and held with receive_sig until data_ack; a frame arriving while still held is dropped (overrun).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int clk_per_bit = 87,
    parameter int data_bits   = 8,
    parameter int parity_mode = 0,
    parameter int stop_bits   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_data,
    output logic [data_bits-1:0] data,
    output logic                 receive_sig,
    input  logic                 data_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam logic [3:0] BIT_LAST  = 4'(data_bits - 1);
    localparam logic       STOP_LAST = (stop_bits == 2);

    logic [1:0]           sync_q;
    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [data_bits-1:0] shreg_q, shreg_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [data_bits-1:0] data_q, data_d;
    logic                 recv_q, recv_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 restart;
    logic                 mid_tick;
    logic                 end_tick;
    logic                 par_exp;

    assign rx_s    = sync_q[1];
    assign par_exp = (parity_mode == PAR_ODD) ? ~(^shreg_q) : (^shreg_q);

    uart_baud_tick #(
        .clk_per_bit(clk_per_bit)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .mid_tick(mid_tick),
        .end_tick(end_tick)
    );

    // Re-centring the timer at the start-bit midpoint makes every later end_tick land mid-bit.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        restart    = 1'b0;
        case (state_q)
            IDLE: begin
                restart = 1'b1;
                if (!rx_s) begin
                    state_d    = START;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            START: begin
                if (mid_tick) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        restart = 1'b1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (end_tick) begin
                    // LSB arrives first, so after data_bits shifts bit i holds the i-th bit.
                    shreg_d = {rx_s, shreg_q[data_bits-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = (parity_mode != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (end_tick) begin
                    if (rx_s != par_exp) begin
                        perr_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (end_tick) begin
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = DONE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d       = data_q;
        recv_d       = recv_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        if (state_q == DONE) begin
            if (!recv_q || data_ack) begin
                data_d       = shreg_q;
                parity_err_d = perr_q;
                frame_err_d  = ferr_q;
                overrun_d    = 1'b0;
                recv_d       = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_ack && recv_q) begin
            recv_d       = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            recv_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_data};
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_q       <= data_d;
            recv_q       <= recv_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data        = data_q;
    assign receive_sig = recv_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E2, 5O1) on a shared 100 ns clock;
// serial stimulus changes on negedges so frame timing is cycle exact.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;
    logic [2:0] ack_v = 3'b000;

    int errors = 0;
    int checks = 0;

    logic [7:0] data0, data1;
    logic [4:0] data2;
    logic       rs0, pe0, fe0, ov0, busy0;
    logic       rs1, pe1, fe1, ov1, busy1;
    logic       rs2, pe2, fe2, ov2, busy2;

    always #50 clk = ~clk;

    uart_rx_cfg #(.clk_per_bit(87), .data_bits(8), .parity_mode(0), .stop_bits(1)) u0 (
        .clk(clk), .reset(rst_n), .rx_data(rx_line[0]), .data(data0), .receive_sig(rs0),
        .data_ack(ack_v[0]), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .rx_busy(busy0));

    uart_rx_cfg #(.clk_per_bit(87), .data_bits(8), .parity_mode(1), .stop_bits(2)) u1 (
        .clk(clk), .reset(rst_n), .rx_data(rx_line[1]), .data(data1), .receive_sig(rs1),
        .data_ack(ack_v[1]), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .rx_busy(busy1));

    uart_rx_cfg #(.clk_per_bit(87), .data_bits(5), .parity_mode(2), .stop_bits(1)) u2 (
        .clk(clk), .reset(rst_n), .rx_data(rx_line[2]), .data(data2), .receive_sig(rs2),
        .data_ack(ack_v[2]), .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .rx_busy(busy2));

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one frame on rx_line[idx], one position per 87 cycles, starting at a negedge.
    // par < 0 means no parity bit; ack_at >= 0 pulses data_ack for the cycle k == ack_at.
    task automatic send(input int idx, input logic [8:0] pay, input int nbits, input int par,
                        input int nstop, input logic stop2, input int ack_at);
        logic [15:0] fb;
        int len;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < nbits; i++) fb[1 + i] = pay[i];
        len = 1 + nbits;
        if (par >= 0) begin
            fb[len] = par[0];
            len++;
        end
        fb[len] = 1'b1;
        len++;
        if (nstop == 2) begin
            fb[len] = stop2;
            len++;
        end
        for (int k = 0; k < 87 * len; k++) begin
            rx_line[idx] = fb[k / 87];
            ack_v[idx] = (k == ack_at);
            @(negedge clk);
        end
        rx_line[idx] = 1'b1;
        ack_v[idx] = 1'b0;
    endtask

    task automatic pulse_ack(input int idx);
        ack_v[idx] = 1'b1;
        @(negedge clk);
        ack_v[idx] = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rs0", 9'(rs0), 9'h0);
        chk("reset_data0", 9'(data0), 9'h0);
        chk("reset_busy0", 9'(busy0), 9'h0);
        chk("reset_flags0", 9'({pe0, fe0, ov0}), 9'h0);
        chk("reset_busy1", 9'(busy1), 9'h0);

        // 8N1 basic frame and acknowledge
        send(0, 9'h3F, 8, -1, 1, 1'b1, -1);
        chk("3f_rs", 9'(rs0), 9'h1);
        chk("3f_data", 9'(data0), 9'h3F);
        chk("3f_flags", 9'({pe0, fe0, ov0}), 9'h0);
        pulse_ack(0);
        chk("3f_ack_rs", 9'(rs0), 9'h0);

        // even parity: A5 has four ones, correct parity bit is 0
        send(1, 9'hA5, 8, 1, 2, 1'b1, -1);
        chk("a5_bad_rs", 9'(rs1), 9'h1);
        chk("a5_bad_data", 9'(data1), 9'hA5);
        chk("a5_bad_pe", 9'(pe1), 9'h1);
        pulse_ack(1);
        chk("a5_ack_pe", 9'({rs1, pe1}), 9'h0);
        send(1, 9'hA5, 8, 0, 2, 1'b1, -1);
        chk("a5_good_rs", 9'(rs1), 9'h1);
        chk("a5_good_pe", 9'(pe1), 9'h0);
        pulse_ack(1);

        // second stop bit low -> framing error, payload still published
        send(1, 9'h55, 8, 0, 2, 1'b0, -1);
        chk("55_fe", 9'(fe1), 9'h1);
        chk("55_data", 9'(data1), 9'h55);
        chk("55_pe", 9'(pe1), 9'h0);
        pulse_ack(1);
        send(1, 9'h12, 8, 0, 2, 1'b1, -1);
        chk("12_data", 9'(data1), 9'h12);
        chk("12_flags", 9'({rs1, pe1, fe1, ov1}), 9'h8);
        pulse_ack(1);

        // overrun: second frame dropped while first is still held
        send(0, 9'h11, 8, -1, 1, 1'b1, -1);
        send(0, 9'h22, 8, -1, 1, 1'b1, -1);
        chk("ovr_data", 9'(data0), 9'h11);
        chk("ovr_flag", 9'({rs0, ov0}), 9'h3);
        pulse_ack(0);
        chk("ovr_ack", 9'({rs0, pe0, fe0, ov0}), 9'h0);
        send(0, 9'h33, 8, -1, 1, 1'b1, -1);
        chk("33_data", 9'(data0), 9'h33);
        chk("33_ov", 9'({rs0, ov0}), 9'h2);
        pulse_ack(0);

        // 10-cycle glitch: START after P2, midpoint check after P45, IDLE after P46
        rx_line[0] = 1'b0;
        repeat (10) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (36) @(negedge clk);
        chk("glitch_busy_mid", 9'(busy0), 9'h1);
        @(negedge clk);
        chk("glitch_busy_end", 9'(busy0), 9'h0);
        chk("glitch_rs", 9'(rs0), 9'h0);

        // ack in the exact DONE cycle of a second frame: DONE is the cycle before P830
        send(0, 9'h3F, 8, -1, 1, 1'b1, -1);
        chk("done_first", 9'(data0), 9'h3F);
        send(0, 9'h5A, 8, -1, 1, 1'b1, 830);
        chk("done_ack_data", 9'(data0), 9'h5A);
        chk("done_ack_flags", 9'({rs0, ov0}), 9'h2);
        pulse_ack(0);

        // 5-bit odd parity: 1B has four ones, correct odd parity bit is 1
        send(2, 9'h1B, 5, 1, 1, 1'b1, -1);
        chk("1b_data", 9'(data2), 9'h1B);
        chk("1b_flags", 9'({rs2, pe2, fe2, ov2}), 9'h8);

        // reset mid-frame while a frame is still held
        rx_line[2] = 1'b0;
        repeat (300) @(negedge clk);
        chk("pre_reset_busy", 9'(busy2), 9'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_data2", 9'(data2), 9'h0);
        chk("rst_outs2", 9'({rs2, pe2, fe2, ov2, busy2}), 9'h0);
        rst_n = 1'b1;
        rx_line[2] = 1'b1;
        repeat (1000) @(negedge clk);
        chk("post_reset_rs2", 9'({rs2, busy2}), 9'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
